// File: rtl/hamming_syndrome_gen.sv
// Assembles a 16-bit SECDED codeword from two bytes, classifies it and emits the
// position syndrome for the flip-mask LUT stage, with saturating SEC/DED counters.
module hamming_syndrome_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       pflip,
    output logic             err_single,
    output logic             err_double,
    output logic             p0_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count
);
    typedef enum logic [1:0] {IDLE, GOT_LSW, CALC, DONE} state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [7:0]       lsw_q;
    logic [7:0]       msw_q;
    logic [7:0]       pflip_q;
    logic             err_single_q;
    logic             err_double_q;
    logic             p0_err_q;
    logic [CNT_W-1:0] sec_q;
    logic [CNT_W-1:0] ded_q;
    logic [CNT_W-1:0] sec_d;
    logic [CNT_W-1:0] ded_d;
    logic [3:0]       syn_d;
    logic             par_d;
    logic             single_d;
    logic             double_d;
    logic             p0_d;
    logic             in_hs;

    // Each mask selects the positions whose index has syndrome bit k set.
    function automatic logic [3:0] syndrome(input logic [15:0] cw);
        return {^(cw & 16'hFF00), ^(cw & 16'hF0F0), ^(cw & 16'hCCCC), ^(cw & 16'hAAAA)};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign in_hs = in_valid && in_ready_q;

    always_comb begin
        syn_d    = syndrome({msw_q, lsw_q});
        par_d    = ^{msw_q, lsw_q};
        single_d = par_d;
        double_d = (syn_d != 4'd0) && !par_d;
        p0_d     = (syn_d == 4'd0) && par_d;
        sec_d    = sec_q;
        ded_d    = ded_q;
        if (cnt_clr) begin
            sec_d = '0;
            ded_d = '0;
        end else if (state_q == CALC) begin
            if (single_d) sec_d = sat_inc(sec_q);
            if (double_d) ded_d = sat_inc(ded_q);
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs && (state_q == IDLE))    lsw_q <= in_byte;
        if (in_hs && (state_q == GOT_LSW)) msw_q <= in_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            pflip_q      <= 8'h00;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            p0_err_q     <= 1'b0;
            sec_q        <= '0;
            ded_q        <= '0;
        end else begin
            sec_q <= sec_d;
            ded_q <= ded_d;
            case (state_q)
                IDLE: begin
                    if (in_hs) state_q <= GOT_LSW;
                end
                GOT_LSW: begin
                    if (in_hs) begin
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                    end
                end
                CALC: begin
                    state_q      <= DONE;
                    out_valid_q  <= 1'b1;
                    pflip_q      <= {4'b0000, syn_d};
                    err_single_q <= single_d;
                    err_double_q <= double_d;
                    p0_err_q     <= p0_d;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign pflip      = pflip_q;
    assign err_single = err_single_q;
    assign err_double = err_double_q;
    assign p0_err     = p0_err_q;
    assign sec_count  = sec_q;
    assign ded_count  = ded_q;
endmodule
